// File: rtl/kv_sb_pkg.sv
// Shared types and helpers for the store buffer: the entry record and the
// word-granular address compare used by store-to-load forwarding.
package kv_sb_pkg;

    localparam int KV_ADDR_W = 32;
    localparam int KV_DATA_W = 32;

    typedef struct packed {
        logic                 valid;
        logic [KV_ADDR_W-1:0] addr;
        logic [KV_DATA_W-1:0] data;
    } sb_entry_t;

    // Word match: byte offset bits [1:0] are discarded by the shift.
    function automatic logic word_match(input logic [KV_ADDR_W-1:0] a,
                                        input logic [KV_ADDR_W-1:0] b);
        return (((a ^ b) >> 2) == {KV_ADDR_W{1'b0}});
    endfunction

endpackage

// File: rtl/kv_sb_age_rotator.sv
// Reorders physical slots into age order (index 0 = youngest) and flags
// every live slot whose word address matches the lookup address.
module kv_sb_age_rotator
    import kv_sb_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int PTR_W = $clog2(DEPTH)
) (
    input  sb_entry_t [DEPTH-1:0]                slots,
    input  logic      [PTR_W-1:0]                tail,
    input  logic      [KV_ADDR_W-1:0]            lkup_addr,
    output logic      [DEPTH-1:0][KV_DATA_W-1:0] fwd_datas,
    output logic      [DEPTH-1:0]                fwd_valid
);

    logic [PTR_W-1:0] slot_s;

    // Age k lives in slot (tail-1-k); pointer width gives the modulo for free.
    always_comb begin
        fwd_datas = '0;
        fwd_valid = '0;
        slot_s    = '0;
        for (int k = 0; k < DEPTH; k++) begin
            slot_s       = tail - PTR_W'(1) - PTR_W'(k);
            fwd_datas[k] = slots[slot_s].data;
            fwd_valid[k] = slots[slot_s].valid && word_match(slots[slot_s].addr, lkup_addr);
        end
    end

endmodule

// File: rtl/kv_store_buffer.sv
// Circular store buffer between commit and the data-cache write port, with
// a combinational age-ordered lookup for store-to-load forwarding.
module kv_store_buffer
    import kv_sb_pkg::*;
#(
    // Widths must match the entry record in kv_sb_pkg.
    parameter int DATA_WIDTH = KV_DATA_W,
    parameter int ADDR_WIDTH = KV_ADDR_W,
    parameter int DEPTH      = 4
) (
    input  logic                             i_clk,
    input  logic                             i_rst_n,
    input  logic                             i_enq_valid,
    output logic                             o_enq_ready,
    input  logic [ADDR_WIDTH-1:0]            i_enq_addr,
    input  logic [DATA_WIDTH-1:0]            i_enq_data,
    output logic                             o_drain_valid,
    input  logic                             i_drain_ready,
    output logic [ADDR_WIDTH-1:0]            o_drain_addr,
    output logic [DATA_WIDTH-1:0]            o_drain_data,
    input  logic [ADDR_WIDTH-1:0]            i_lkup_addr,
    output logic [DEPTH-1:0][DATA_WIDTH-1:0] o_fwd_datas,
    output logic [DEPTH-1:0]                 o_fwd_valid,
    output logic                             o_fwd_hit,
    output logic [$clog2(DEPTH):0]           o_count,
    output logic                             o_empty,
    output logic                             o_full
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [PTR_W-1:0]      head_r;
    logic [PTR_W-1:0]      tail_r;
    logic [CNT_W-1:0]      count_r;
    logic [DEPTH-1:0]      valid_r;
    logic [DEPTH-1:0]      valid_next_s;
    logic [ADDR_WIDTH-1:0] addr_r [DEPTH];
    logic [DATA_WIDTH-1:0] data_r [DEPTH];
    sb_entry_t [DEPTH-1:0] entries_s;

    logic full_s;
    logic empty_s;
    logic enq_fire_s;
    logic drain_fire_s;

    assign full_s       = (count_r == CNT_W'(DEPTH));
    assign empty_s      = (count_r == {CNT_W{1'b0}});
    assign enq_fire_s   = i_enq_valid && !full_s;
    assign drain_fire_s = !empty_s && i_drain_ready;

    assign o_enq_ready   = !full_s;
    assign o_drain_valid = !empty_s;
    assign o_drain_addr  = addr_r[head_r];
    assign o_drain_data  = data_r[head_r];
    assign o_count       = count_r;
    assign o_empty       = empty_s;
    assign o_full        = full_s;
    assign o_fwd_hit     = |o_fwd_valid;

    // Next slot-valid vector: drain clears head, enqueue sets tail.
    always_comb begin
        valid_next_s = valid_r;
        if (drain_fire_s) begin
            valid_next_s[head_r] = 1'b0;
        end else begin
            valid_next_s = valid_r;
        end
        if (enq_fire_s) begin
            valid_next_s[tail_r] = 1'b1;
        end else begin
            valid_next_s[tail_r] = valid_next_s[tail_r];
        end
    end

    // Pointers, occupancy and valid bits; reset discards every entry at once.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            head_r  <= {PTR_W{1'b0}};
            tail_r  <= {PTR_W{1'b0}};
            count_r <= {CNT_W{1'b0}};
            valid_r <= {DEPTH{1'b0}};
        end else begin
            valid_r <= valid_next_s;
            if (enq_fire_s) begin
                tail_r <= tail_r + PTR_W'(1);
            end
            if (drain_fire_s) begin
                head_r <= head_r + PTR_W'(1);
            end
            case ({enq_fire_s, drain_fire_s})
                2'b10:   count_r <= count_r + CNT_W'(1);
                2'b01:   count_r <= count_r - CNT_W'(1);
                default: count_r <= count_r;
            endcase
        end
    end

    // Entry payload storage; deliberately not reset, qualified by valid_r.
    always_ff @(posedge i_clk) begin
        if (enq_fire_s) begin
            addr_r[tail_r] <= i_enq_addr;
            data_r[tail_r] <= i_enq_data;
        end
    end

    // Pack registers into entry records for the rotator.
    always_comb begin
        entries_s = '0;
        for (int i = 0; i < DEPTH; i++) begin
            entries_s[i].valid = valid_r[i];
            entries_s[i].addr  = addr_r[i];
            entries_s[i].data  = data_r[i];
        end
    end

    kv_sb_age_rotator #(
        .DEPTH (DEPTH),
        .PTR_W (PTR_W)
    ) u_rotator (
        .slots     (entries_s),
        .tail      (tail_r),
        .lkup_addr (i_lkup_addr),
        .fwd_datas (o_fwd_datas),
        .fwd_valid (o_fwd_valid)
    );

endmodule
